trap_ctrl: RTL and testbench

- Parametrised machine-mode trap controller for the core. Successor to the single-cause exception sequencer.
- Arbitrates interrupts (software, timer, external and N maskable fast IRQs), synchronous exceptions (ecall, ebreak, illegal instruction, misaligned fetch), mret/dret and debug entry.
- Sequences the architectural CSR updates (mcause, mepc, mtval, mstatus) over a single CSR write port, then redirects fetch.
- Adds four capabilities: mtvec direct/vectored modes, mstatus MIE/MPIE save and restore, mtval reporting, and a parametrised fast-IRQ count.

---
 rtl/trap_pkg.sv | 49 ++++
 rtl/trap_prio_enc.sv | 34 +++
 rtl/trap_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_trap_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_pkg.sv
// trap_pkg: shared types and constants for the machine-mode trap controller.
//   state_e       one-hot sequencer states
//   CAUSE_*       synchronous exception cause codes
//   IRQ_CODE_*    interrupt cause codes (low bits of mcause)
//   MSTATUS_* / MIE_* / DCSR_*  CSR bit positions
//   CSR_*         CSR addresses, widened to the write port with csr_addr()
package trap_pkg;

    typedef enum logic [4:0] {
        S_IDLE      = 5'b00001,
        S_W_MEPC    = 5'b00010,
        S_W_MTVAL   = 5'b00100,
        S_W_MSTATUS = 5'b01000,
        S_ASSERT    = 5'b10000
    } state_e;

    localparam logic [31:0] CAUSE_MISALIGN = 32'd0;
    localparam logic [31:0] CAUSE_ILLEGAL  = 32'd2;
    localparam logic [31:0] CAUSE_EBREAK   = 32'd3;
    localparam logic [31:0] CAUSE_ECALL    = 32'd11;

    localparam logic [4:0] IRQ_CODE_SW        = 5'd3;
    localparam logic [4:0] IRQ_CODE_TMR       = 5'd7;
    localparam logic [4:0] IRQ_CODE_EXT       = 5'd11;
    localparam logic [4:0] IRQ_CODE_FAST_BASE = 5'd16;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam int MIE_MSIE      = 3;
    localparam int MIE_MTIE      = 7;
    localparam int MIE_MEIE      = 11;
    localparam int MIE_FAST_BASE = 16;

    localparam int DCSR_EBREAKM = 15;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
    localparam logic [11:0] CSR_DPC     = 12'h7B1;

    function automatic logic [31:0] csr_addr(input logic [11:0] a);
        return {20'h0, a};
    endfunction

endpackage

// File: rtl/trap_prio_enc.sv
// trap_prio_enc: fixed-priority encoder over the pending interrupt lines.
//   fast_i   pending fast IRQs (index 0 highest priority overall)
//   ext_i / sw_i / tmr_i  pending external, software, timer (in that order)
//   valid_o  any line pending
//   code_o   cause code of the winning line
module trap_prio_enc
    import trap_pkg::*;
#(
    parameter int NUM_FAST_IRQ = 15
) (
    input  logic [NUM_FAST_IRQ-1:0] fast_i,
    input  logic                    ext_i,
    input  logic                    sw_i,
    input  logic                    tmr_i,
    output logic                    valid_o,
    output logic [4:0]              code_o
);

    // Evaluate from lowest to highest priority; the last hit wins.
    always_comb begin
        valid_o = 1'b0;
        code_o  = '0;
        if (tmr_i) begin valid_o = 1'b1; code_o = IRQ_CODE_TMR; end
        if (sw_i)  begin valid_o = 1'b1; code_o = IRQ_CODE_SW;  end
        if (ext_i) begin valid_o = 1'b1; code_o = IRQ_CODE_EXT; end
        for (int i = NUM_FAST_IRQ - 1; i >= 0; i--) begin
            if (fast_i[i]) begin
                valid_o = 1'b1;
                code_o  = IRQ_CODE_FAST_BASE + 5'(i);
            end
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap controller. Arbitrates exceptions, interrupts,
// mret/dret and debug entry, sequences mcause/mepc/mtval/mstatus over one CSR
// write port, then pulses a one-cycle fetch redirect.
//   inst_*_i       instruction in EX and its decoded system-op flags
//   *_i CSR values mtvec/mepc/mstatus/mie/dpc/dcsr current contents
//   irq_*_i        level interrupt requests; debug_req_i halt request
//   csr_we_o/csr_waddr_o/csr_wdata_o  CSR write port
//   stall_flag_o   hold the pipeline while a request is being sequenced
//   int_assert_o/int_addr_o  fetch redirect; debug_mode_o debug state
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int NUM_FAST_IRQ = 15,
    parameter bit DEBUG_EN     = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    inst_valid_i,
    input  logic [31:0]             inst_addr_i,
    input  logic                    inst_ecall_i,
    input  logic                    inst_ebreak_i,
    input  logic                    inst_mret_i,
    input  logic                    inst_dret_i,
    input  logic                    inst_illegal_i,
    input  logic                    inst_misalign_i,
    input  logic [31:0]             inst_data_i,
    input  logic [31:0]             mtvec_i,
    input  logic [31:0]             mepc_i,
    input  logic [31:0]             mstatus_i,
    input  logic [31:0]             mie_i,
    input  logic [31:0]             dpc_i,
    input  logic [31:0]             dcsr_i,
    input  logic                    irq_software_i,
    input  logic                    irq_timer_i,
    input  logic                    irq_external_i,
    input  logic [NUM_FAST_IRQ-1:0] irq_fast_i,
    input  logic                    debug_req_i,
    input  logic [31:0]             debug_halt_addr_i,
    output logic                    csr_we_o,
    output logic [31:0]             csr_waddr_o,
    output logic [31:0]             csr_wdata_o,
    output logic                    stall_flag_o,
    output logic                    int_assert_o,
    output logic [31:0]             int_addr_o,
    output logic                    debug_mode_o
);

    state_e      state_q, state_d;
    logic [31:0] cause_q, cause_d, tval_q, tval_d, tgt_q, tgt_d, epc_q, epc_d;
    logic        dmode_q, dmode_d;

    logic        irq_vld, irq_take, ebreak_exc, exc, trap, dbg_entry, dret_req, req_any;
    logic [4:0]  irq_code;
    logic [31:0] trap_cause, trap_tval, trap_tgt, base, ms_trap, ms_mret;
    logic        unused_ok;

    // Only a few bits of mie/dcsr matter here.
    assign unused_ok = ^{dcsr_i, mie_i};

    trap_prio_enc #(.NUM_FAST_IRQ(NUM_FAST_IRQ)) u_prio (
        .fast_i  (irq_fast_i & mie_i[MIE_FAST_BASE +: NUM_FAST_IRQ]),
        .ext_i   (irq_external_i & mie_i[MIE_MEIE]),
        .sw_i    (irq_software_i & mie_i[MIE_MSIE]),
        .tmr_i   (irq_timer_i & mie_i[MIE_MTIE]),
        .valid_o (irq_vld),
        .code_o  (irq_code)
    );

    assign irq_take   = irq_vld & inst_valid_i & mstatus_i[MSTATUS_MIE] & ~dmode_q;
    assign ebreak_exc = inst_ebreak_i & ~dcsr_i[DCSR_EBREAKM] & ~dmode_q;
    assign exc        = inst_illegal_i | inst_misalign_i | inst_ecall_i | ebreak_exc;
    assign trap       = exc | irq_take;
    assign dbg_entry  = DEBUG_EN && ((debug_req_i && inst_valid_i && !dmode_q) ||
                                     (inst_ebreak_i && (dcsr_i[DCSR_EBREAKM] || dmode_q)));
    assign dret_req   = DEBUG_EN && inst_dret_i;
    assign req_any    = trap | dbg_entry | inst_mret_i | dret_req;
    assign base       = {mtvec_i[31:2], 2'b00};

    always_comb begin
        trap_tval = '0;
        trap_tgt  = base;
        if (inst_illegal_i) begin
            trap_cause = CAUSE_ILLEGAL;
            trap_tval  = inst_data_i;
        end else if (inst_misalign_i) begin
            trap_cause = CAUSE_MISALIGN;
            trap_tval  = inst_addr_i;
        end else if (inst_ecall_i) begin
            trap_cause = CAUSE_ECALL;
        end else if (ebreak_exc) begin
            trap_cause = CAUSE_EBREAK;
        end else begin
            trap_cause = {1'b1, 26'h0, irq_code};
            // Only mode 1 vectors; modes 2/3 fall back to direct.
            if (mtvec_i[1:0] == 2'b01) trap_tgt = base + {25'h0, irq_code, 2'b00};
        end
    end

    always_comb begin
        ms_trap = mstatus_i;
        ms_trap[MSTATUS_MPIE] = mstatus_i[MSTATUS_MIE];
        ms_trap[MSTATUS_MIE]  = 1'b0;
        ms_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        ms_mret = mstatus_i;
        ms_mret[MSTATUS_MIE]  = mstatus_i[MSTATUS_MPIE];
        ms_mret[MSTATUS_MPIE] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cause_q <= '0;
            tval_q  <= '0;
            tgt_q   <= '0;
            epc_q   <= '0;
            dmode_q <= 1'b0;
        end else begin
            cause_q <= cause_d;
            tval_q  <= tval_d;
            tgt_q   <= tgt_d;
            epc_q   <= epc_d;
            dmode_q <= dmode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        tval_d  = tval_q;
        tgt_d   = tgt_q;
        epc_d   = epc_q;
        dmode_d = dmode_q;
        case (state_q)
            S_IDLE: begin
                if (trap) begin
                    cause_d = trap_cause;
                    tval_d  = trap_tval;
                    tgt_d   = trap_tgt;
                    epc_d   = inst_addr_i;
                    state_d = S_W_MEPC;
                end else if (dbg_entry) begin
                    dmode_d = 1'b1;
                    tgt_d   = debug_halt_addr_i;
                    state_d = S_ASSERT;
                end else if (inst_mret_i) begin
                    tgt_d   = mepc_i;
                    state_d = S_ASSERT;
                end else if (dret_req) begin
                    tgt_d   = dpc_i;
                    dmode_d = 1'b0;
                    state_d = S_ASSERT;
                end
            end
            S_W_MEPC:    state_d = S_W_MTVAL;
            S_W_MTVAL:   state_d = S_W_MSTATUS;
            S_W_MSTATUS: state_d = S_ASSERT;
            S_ASSERT:    state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Outputs are forced low while reset is held so an abort is visible at once.
    always_comb begin
        csr_we_o     = 1'b0;
        csr_waddr_o  = '0;
        csr_wdata_o  = '0;
        stall_flag_o = 1'b0;
        int_assert_o = 1'b0;
        int_addr_o   = '0;
        if (rst_n) begin
            case (state_q)
                S_IDLE: begin
                    stall_flag_o = req_any;
                    if (trap) begin
                        csr_we_o    = 1'b1;
                        csr_waddr_o = csr_addr(CSR_MCAUSE);
                        csr_wdata_o = trap_cause;
                    end else if (dbg_entry) begin
                        // A nested ebreak in debug mode must keep the original dpc.
                        csr_we_o    = ~(inst_ebreak_i & dmode_q);
                        csr_waddr_o = csr_addr(CSR_DPC);
                        csr_wdata_o = inst_addr_i;
                    end else if (inst_mret_i) begin
                        csr_we_o    = 1'b1;
                        csr_waddr_o = csr_addr(CSR_MSTATUS);
                        csr_wdata_o = ms_mret;
                    end
                end
                S_W_MEPC: begin
                    stall_flag_o = 1'b1;
                    csr_we_o     = 1'b1;
                    csr_waddr_o  = csr_addr(CSR_MEPC);
                    csr_wdata_o  = epc_q;
                end
                S_W_MTVAL: begin
                    stall_flag_o = 1'b1;
                    csr_we_o     = 1'b1;
                    csr_waddr_o  = csr_addr(CSR_MTVAL);
                    csr_wdata_o  = tval_q;
                end
                S_W_MSTATUS: begin
                    stall_flag_o = 1'b1;
                    csr_we_o     = 1'b1;
                    csr_waddr_o  = csr_addr(CSR_MSTATUS);
                    csr_wdata_o  = ms_trap;
                end
                S_ASSERT: begin
                    int_assert_o = 1'b1;
                    int_addr_o   = tgt_q;
                end
                default: ;
            endcase
        end
    end

    assign debug_mode_o = DEBUG_EN && dmode_q;

endmodule

// File: tb/tb_trap_ctrl.sv
module tb_trap_ctrl;

    localparam int NF = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          inst_valid_i, inst_ecall_i, inst_ebreak_i, inst_mret_i, inst_dret_i;
    logic          inst_illegal_i, inst_misalign_i;
    logic [31:0]   inst_addr_i, inst_data_i;
    logic [31:0]   mtvec_i, mepc_i, mstatus_i, mie_i, dpc_i, dcsr_i;
    logic          irq_software_i, irq_timer_i, irq_external_i, debug_req_i;
    logic [NF-1:0] irq_fast_i;
    logic [31:0]   debug_halt_addr_i;
    logic          csr_we_o, stall_flag_o, int_assert_o, debug_mode_o;
    logic [31:0]   csr_waddr_o, csr_wdata_o, int_addr_o;

    trap_ctrl #(.NUM_FAST_IRQ(NF), .DEBUG_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .inst_valid_i(inst_valid_i), .inst_addr_i(inst_addr_i),
        .inst_ecall_i(inst_ecall_i), .inst_ebreak_i(inst_ebreak_i),
        .inst_mret_i(inst_mret_i), .inst_dret_i(inst_dret_i),
        .inst_illegal_i(inst_illegal_i), .inst_misalign_i(inst_misalign_i),
        .inst_data_i(inst_data_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
        .mstatus_i(mstatus_i), .mie_i(mie_i), .dpc_i(dpc_i), .dcsr_i(dcsr_i),
        .irq_software_i(irq_software_i), .irq_timer_i(irq_timer_i),
        .irq_external_i(irq_external_i), .irq_fast_i(irq_fast_i),
        .debug_req_i(debug_req_i), .debug_halt_addr_i(debug_halt_addr_i),
        .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
        .stall_flag_o(stall_flag_o), .int_assert_o(int_assert_o),
        .int_addr_o(int_addr_o), .debug_mode_o(debug_mode_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          redir;
        logic [31:0] a;
        logic [31:0] d;
    } ev_t;

    ev_t sb[$];
    int  total = 0, bad = 0, cyc = 0, last_asrt = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic exp_csr(input logic [11:0] a, input logic [31:0] d);
        ev_t e;
        e.redir = 1'b0; e.a = {20'h0, a}; e.d = d;
        sb.push_back(e);
    endtask

    task automatic exp_redir(input logic [31:0] a);
        ev_t e;
        e.redir = 1'b1; e.a = a; e.d = '0;
        sb.push_back(e);
    endtask

    // Scoreboard side: every CSR write and redirect pops the next expected event.
    always @(negedge clk) begin
        ev_t e;
        if (rst_n) begin
            if (csr_we_o) begin
                if (sb.size() == 0) chk("spurious_we", 32'(csr_we_o), 32'd0);
                else begin
                    e = sb.pop_front();
                    chk("kind_we", 32'(e.redir), 32'd0);
                    chk("csr_waddr", csr_waddr_o, e.a);
                    chk("csr_wdata", csr_wdata_o, e.d);
                end
            end
            if (int_assert_o) begin
                last_asrt = cyc;
                if (sb.size() == 0) chk("spurious_asrt", 32'(int_assert_o), 32'd0);
                else begin
                    e = sb.pop_front();
                    chk("kind_asrt", 32'(e.redir), 32'd1);
                    chk("int_addr", int_addr_o, e.a);
                end
            end
        end
    end

    task automatic clr_req();
        inst_ecall_i = 0; inst_ebreak_i = 0; inst_mret_i = 0; inst_dret_i = 0;
        inst_illegal_i = 0; inst_misalign_i = 0;
        irq_software_i = 0; irq_timer_i = 0; irq_external_i = 0; irq_fast_i = '0;
        debug_req_i = 0;
    endtask

    // Requests are set just after a posedge; hold them for the accept cycle only.
    task automatic fire(input string tag, input int lat);
        int c0;
        c0 = cyc;
        @(negedge clk);
        chk({tag, "_stall"}, 32'(stall_flag_o), 32'd1);
        @(posedge clk); #1;
        clr_req();
        repeat (6) @(posedge clk);
        #1;
        chk({tag, "_drain"}, sb.size(), 32'd0);
        chk({tag, "_lat"}, last_asrt - c0, lat);
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int prev;
        rst_n = 0;
        clr_req();
        inst_valid_i = 1; inst_addr_i = 0; inst_data_i = 0;
        mtvec_i = 0; mepc_i = 0; mstatus_i = 0; mie_i = 0; dpc_i = 0; dcsr_i = 0;
        debug_halt_addr_i = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we", 32'(csr_we_o), 0);
        chk("rst_waddr", csr_waddr_o, 0);
        chk("rst_wdata", csr_wdata_o, 0);
        chk("rst_stall", 32'(stall_flag_o), 0);
        chk("rst_asrt", 32'(int_assert_o), 0);
        chk("rst_iaddr", int_addr_o, 0);
        chk("rst_dbg", 32'(debug_mode_o), 0);
        rst_n = 1;
        @(posedge clk); #1;

        // Timer, vectored
        mtvec_i = 32'h1000_0001; mie_i = 32'h80; mstatus_i = 32'h8;
        inst_addr_i = 32'h200; irq_timer_i = 1;
        exp_csr(12'h342, 32'h8000_0007); exp_csr(12'h341, 32'h200);
        exp_csr(12'h343, 32'h0); exp_csr(12'h300, 32'h1880);
        exp_redir(32'h1000_001C);
        fire("timer", 4);

        // Illegal beats pending external IRQ
        mtvec_i = 32'h800; mie_i = 32'h800; mstatus_i = 32'h8;
        inst_addr_i = 32'h300; inst_data_i = 32'hFFFF_FFFF;
        irq_external_i = 1; inst_illegal_i = 1;
        exp_csr(12'h342, 32'h2); exp_csr(12'h341, 32'h300);
        exp_csr(12'h343, 32'hFFFF_FFFF); exp_csr(12'h300, 32'h1880);
        exp_redir(32'h800);
        fire("illegal", 4);

        // Two fast lines, lowest index wins, vectored
        mtvec_i = 32'h2001; mie_i = 32'h0028_0000; mstatus_i = 32'h8;
        inst_addr_i = 32'h400; irq_fast_i = 15'h28;
        exp_csr(12'h342, 32'h8000_0013); exp_csr(12'h341, 32'h400);
        exp_csr(12'h343, 32'h0); exp_csr(12'h300, 32'h1880);
        exp_redir(32'h204C);
        fire("fast", 4);

        // Same with MIE clear: nothing taken
        mstatus_i = 32'h0; irq_fast_i = 15'h28;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mask_stall", 32'(stall_flag_o), 0);
        end
        @(posedge clk); #1;
        clr_req();

        // Software IRQ with mtvec mode 2 behaves as direct
        mtvec_i = 32'h3002; mie_i = 32'h8; mstatus_i = 32'h8;
        inst_addr_i = 32'h500; irq_software_i = 1;
        exp_csr(12'h342, 32'h8000_0003); exp_csr(12'h341, 32'h500);
        exp_csr(12'h343, 32'h0); exp_csr(12'h300, 32'h1880);
        exp_redir(32'h3000);
        fire("sw_mode2", 4);

        // Misaligned: exceptions never vector
        mtvec_i = 32'h1001; inst_addr_i = 32'h604; inst_misalign_i = 1;
        exp_csr(12'h342, 32'h0); exp_csr(12'h341, 32'h604);
        exp_csr(12'h343, 32'h604); exp_csr(12'h300, 32'h1880);
        exp_redir(32'h1000);
        fire("misalign", 4);

        // ecall beats ebreak, mtval 0
        inst_addr_i = 32'h608; inst_data_i = 32'h0010_0073;
        inst_ecall_i = 1; inst_ebreak_i = 1; dcsr_i = 0;
        exp_csr(12'h342, 32'd11); exp_csr(12'h341, 32'h608);
        exp_csr(12'h343, 32'h0); exp_csr(12'h300, 32'h1880);
        exp_redir(32'h1000);
        fire("ecall", 4);

        // mret
        mstatus_i = 32'h80; mepc_i = 32'h344; inst_mret_i = 1;
        exp_csr(12'h300, 32'h88); exp_redir(32'h344);
        fire("mret", 1);

        // Debug request
        mstatus_i = 32'h0; inst_addr_i = 32'h40; debug_halt_addr_i = 32'h800;
        debug_req_i = 1;
        exp_csr(12'h7B1, 32'h40); exp_redir(32'h800);
        fire("dbgreq", 1);
        chk("dbg_mode_on", 32'(debug_mode_o), 1);

        // ebreak inside debug mode: no dpc write
        inst_addr_i = 32'h50; inst_ebreak_i = 1;
        exp_redir(32'h800);
        fire("dbg_ebreak", 1);
        chk("dbg_mode_hold", 32'(debug_mode_o), 1);

        // dret, with a timer IRQ pending that debug mode must mask
        dpc_i = 32'h40; inst_dret_i = 1;
        mie_i = 32'h80; mstatus_i = 32'h8; irq_timer_i = 1;
        exp_redir(32'h40);
        fire("dret", 1);
        chk("dbg_mode_off", 32'(debug_mode_o), 0);

        // Reset in S_W_MTVAL aborts without a redirect
        mtvec_i = 32'h1000_0001; mie_i = 32'h80; mstatus_i = 32'h8;
        inst_addr_i = 32'h200; irq_timer_i = 1;
        exp_csr(12'h342, 32'h8000_0007); exp_csr(12'h341, 32'h200);
        prev = last_asrt;
        @(posedge clk); #1;
        clr_req();
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        chk("abort_we", 32'(csr_we_o), 0);
        chk("abort_wdata", csr_wdata_o, 0);
        chk("abort_stall", 32'(stall_flag_o), 0);
        chk("abort_asrt", 32'(int_assert_o), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        repeat (6) @(posedge clk);
        #1;
        chk("abort_drain", sb.size(), 0);
        chk("abort_noredir", last_asrt, prev);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
